mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter and sequencer for the processor's shared 512 x 19-bit synchronous `Memory`. It sits between the instruction-fetch unit (read-only port I) and the load/store unit (read/write port D). It grants one access at a time and drives `Memory`'s `address`/`dataIn`/`memWrite`/`memRead` from registers. It captures `dataOut` and returns it to the granted requester with a completion pulse.

## Interface
- `DATA_W`, 19, data word width.
- `ADDR_W`, 19, address width.
- `DEPTH`, 512, number of implemented memory words; addresses >= DEPTH are out of range.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `iReq`  in  1  instruction-port read request.
- `iAddr`  in  ADDR_W  instruction read address.
- `iGnt`  out  1  one-cycle pulse; request accepted.
- `iRvalid`  out  1  one-cycle completion pulse.
- `iRdata`  out  DATA_W  read data; valid while `iRvalid` is high.
- `iErr`  out  1  out-of-range flag; valid while `iRvalid` is high.
- `dReq`  in  1  data-port request.
- `dWe`  in  1  1 = write, 0 = read.
- `dAddr`  in  ADDR_W  data-port address.
- `dWdata`  in  DATA_W  write data.
- `dGnt`, `dRvalid`, `dRdata`, `dErr`  out  same as the I-port equivalents.
- `memAddress`  out  ADDR_W  to `Memory.address`.
- `memDataIn`  out  DATA_W  to `Memory.dataIn`.
- `memWrite`  out  1  to `Memory.memWrite`.
- `memRead`  out  1  to `Memory.memRead`.
- `memDataOut`  in  DATA_W  from `Memory.dataOut`.

## Operation
- FSM states: IDLE, ACCESS, RESP. Reset state is IDLE.
- IDLE or RESP, at a clock edge with `iReq|dReq` high:
  - Select the winner and latch owner, address, write data, write enable and range check.
  - Pulse the winner's `*Gnt` for the next cycle and enter ACCESS.
- IDLE with no request: stay in IDLE.
- RESP with no request: go to IDLE.
- ACCESS:
  - In range: `memRead = ~we`, `memWrite = we`, `memAddress`/`memDataIn` = latched values.
  - Out of range (`addr >= DEPTH`): `memRead` and `memWrite` stay low; no memory access.
  - Always goes to RESP.
- RESP, at its closing edge:
  - Capture `memDataOut` into the owner's `*Rdata` on reads only.
  - Pulse the owner's `*Rvalid` for one cycle.
  - Drive the owner's `*Err` = range-fail.
  - For writes, `*Rdata` holds its previous value.
- Out-of-range reads return `*Rdata` = 0 with `*Err` = 1.
- `memWrite`, `memRead`, `memAddress` and `memDataIn` are low/0 outside ACCESS.
- The I port never writes.
- Default arbitration (macro off): D wins over I whenever both request.
- Requester rules:
  - Hold `*Req`, address and data stable until `*Gnt` is seen.
  - Drop `*Req` in the cycle after `*Gnt` unless issuing a new request.
  - A request raised during ACCESS is sampled at the end of RESP.
- Reset mid-operation:
  - Immediately forces IDLE and all outputs low/0.
  - The in-flight access is abandoned with no `*Rvalid`.
  - A write whose ACCESS cycle has not reached its closing edge does not occur.

## Timing
- All outputs are registered.
- Reset values:
  - `iGnt`, `dGnt`, `iRvalid`, `dRvalid`, `iErr`, `dErr`, `memWrite`, `memRead` = 0.
  - `iRdata`, `dRdata`, `memAddress`, `memDataIn` = 0.
- Request sampled at edge E0.
- `*Gnt` and the ACCESS cycle run between E0 and E1; `Memory` samples at E1.
- RESP runs between E1 and E2; `*Rvalid`/`*Rdata` are visible after E2.
- Latency: 2 cycles from acceptance edge to completion data.
- Back-to-back throughput: one access per 2 cycles, since RESP re-arbitrates.
- Read-after-write to the same address from consecutive grants returns the new data.

## Configuration
- `MEM_ARB_RR_EN` defined:
  - Round-robin arbitration. On a tie, the port not granted last wins.
  - The last-owner register resets to I, so the first tie after reset goes to D.
  - Last owner is updated at every grant.
- Undefined: fixed priority, D over I; no last-owner register.

## Test plan
- Reset, then D write 123 to address 0, then D read of 0 -> `dGnt` 1 cycle after each request edge; `dRvalid` 2 cycles after grant edge; read returns `dRdata` = 123, `dErr` = 0.
- D write 456 to address 1, then I read of 1 -> `iRdata` = 456; `memWrite` never high during I access.
- `iReq` and `dReq` held together for 4 grants:
  - Macro off: D, D, D, D; I starves.
  - Macro on: D, I, D, I.
- D read of address 600 (>= DEPTH) -> `memRead` stays 0; `dRvalid` pulse with `dErr` = 1, `dRdata` = 0.
- D write 77 to address 5 with `rst` asserted during ACCESS -> no `dRvalid`; all outputs 0 immediately; a later read of 5 does not return 77.
- Continuous `iReq` streaming addresses 10, 11, 12 -> a grant every 2 cycles, data in order, no idle cycle between RESP and the next ACCESS.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port (instruction read / data read-write) arbiter and sequencer for a shared synchronous memory.
// Optional round-robin tie-break when MEM_ARB_RR_EN is defined; fixed D-over-I priority otherwise.
module mem_arbiter #(
    parameter int DATA_W = 19,
    parameter int ADDR_W = 19,
    parameter int DEPTH  = 512
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              iReq,
    input  logic [ADDR_W-1:0] iAddr,
    output logic              iGnt,
    output logic              iRvalid,
    output logic [DATA_W-1:0] iRdata,
    output logic              iErr,
    input  logic              dReq,
    input  logic              dWe,
    input  logic [ADDR_W-1:0] dAddr,
    input  logic [DATA_W-1:0] dWdata,
    output logic              dGnt,
    output logic              dRvalid,
    output logic [DATA_W-1:0] dRdata,
    output logic              dErr,
    output logic [ADDR_W-1:0] memAddress,
    output logic [DATA_W-1:0] memDataIn,
    output logic              memWrite,
    output logic              memRead,
    input  logic [DATA_W-1:0] memDataOut,
    output logic [1:0]        dbgState
);

    // Handshake: a requester holds *Req/address/data until it sees *Gnt; *Rvalid
    // pulses for exactly one cycle with *Rdata/*Err valid in that same cycle.

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

    state_t            state;
    logic              ownerD;
    logic              we;
    logic              rangeErr;
    logic              pickD;
    logic              selWe;
    logic              selOor;
    logic [ADDR_W-1:0] selAddr;
    logic [DATA_W-1:0] selData;

`ifdef MEM_ARB_RR_EN
    logic lastD;
`endif

    always_comb begin
`ifdef MEM_ARB_RR_EN
        // On a tie the port that did not win last time goes first.
        pickD = dReq & (~iReq | ~lastD);
`else
        pickD = dReq;
`endif
        selAddr = pickD ? dAddr : iAddr;
        selWe   = pickD & dWe;
        selData = pickD ? dWdata : '0;
        selOor  = {1'b0, selAddr} >= DEPTH_X;
    end

    assign dbgState = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            ownerD     <= 1'b0;
            we         <= 1'b0;
            rangeErr   <= 1'b0;
            iGnt       <= 1'b0;
            dGnt       <= 1'b0;
            iRvalid    <= 1'b0;
            dRvalid    <= 1'b0;
            iErr       <= 1'b0;
            dErr       <= 1'b0;
            iRdata     <= '0;
            dRdata     <= '0;
            memAddress <= '0;
            memDataIn  <= '0;
            memWrite   <= 1'b0;
            memRead    <= 1'b0;
`ifdef MEM_ARB_RR_EN
            lastD      <= 1'b0;
`endif
        end else begin
            iGnt       <= 1'b0;
            dGnt       <= 1'b0;
            iRvalid    <= 1'b0;
            dRvalid    <= 1'b0;
            iErr       <= 1'b0;
            dErr       <= 1'b0;
            memAddress <= '0;
            memDataIn  <= '0;
            memWrite   <= 1'b0;
            memRead    <= 1'b0;

            case (state)
                IDLE, RESP: begin
                    // Closing edge of RESP: memory read data is on memDataOut now.
                    if (state == RESP) begin
                        if (ownerD) begin
                            dRvalid <= 1'b1;
                            dErr    <= rangeErr;
                            if (!we) dRdata <= rangeErr ? '0 : memDataOut;
                        end else begin
                            iRvalid <= 1'b1;
                            iErr    <= rangeErr;
                            if (!we) iRdata <= rangeErr ? '0 : memDataOut;
                        end
                    end

                    if (iReq | dReq) begin
                        ownerD     <= pickD;
                        we         <= selWe;
                        rangeErr   <= selOor;
                        dGnt       <= pickD;
                        iGnt       <= ~pickD;
                        memAddress <= selAddr;
                        memDataIn  <= selData;
                        memRead    <= ~selWe & ~selOor;
                        memWrite   <= selWe & ~selOor;
`ifdef MEM_ARB_RR_EN
                        lastD      <= pickD;
`endif
                        state      <= ACCESS;
                    end else begin
                        state <= IDLE;
                    end
                end
                ACCESS:  state <= RESP;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed table, back-to-back, arbitration, reset abort,
// streaming and randomized transactions checked against a transaction-level memory model.
module tb_mem_arbiter;

    localparam int DW = 19;
    localparam int AW = 19;

    logic          clk, rst;
    logic          iReq, iGnt, iRvalid, iErr;
    logic [AW-1:0] iAddr;
    logic [DW-1:0] iRdata;
    logic          dReq, dWe, dGnt, dRvalid, dErr;
    logic [AW-1:0] dAddr;
    logic [DW-1:0] dWdata, dRdata;
    logic [AW-1:0] memAddress;
    logic [DW-1:0] memDataIn, memDataOut;
    logic          memWrite, memRead;
    logic [1:0]    dbgState;

    int errors = 0;
    int checks = 0;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .iReq(iReq), .iAddr(iAddr), .iGnt(iGnt), .iRvalid(iRvalid), .iRdata(iRdata), .iErr(iErr),
        .dReq(dReq), .dWe(dWe), .dAddr(dAddr), .dWdata(dWdata),
        .dGnt(dGnt), .dRvalid(dRvalid), .dRdata(dRdata), .dErr(dErr),
        .memAddress(memAddress), .memDataIn(memDataIn), .memWrite(memWrite), .memRead(memRead),
        .memDataOut(memDataOut), .dbgState(dbgState)
    );

    // ---------------- clock / reset / memory environment ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0] mem [512];
    initial begin
        for (int i = 0; i < 512; i++) mem[i] = '0;
        memDataOut = '0;
    end
    always @(posedge clk) begin
        if (memWrite) mem[memAddress[8:0]] <= memDataIn;
        if (memRead)  memDataOut <= mem[memAddress[8:0]];
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    // ---------------- reference model (transaction level) ----------------
    logic [DW-1:0] ref_mem [int];
    logic [DW-1:0] last_i, last_d;

    task automatic model_txn(input logic isd, input logic we, input logic [AW-1:0] addr,
                             input logic [DW-1:0] wdata, output logic [DW-1:0] rd, output logic er);
        er = (addr >= 512);
        if (we) begin
            if (!er) ref_mem[int'(addr)] = wdata;
            rd = isd ? last_d : last_i;
        end else begin
            rd = er ? '0 : (ref_mem.exists(int'(addr)) ? ref_mem[int'(addr)] : '0);
            if (isd) last_d = rd; else last_i = rd;
        end
    endtask

    // ---------------- checking / driver tasks ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_ctl"}, {28'd0, iGnt, dGnt, iRvalid, dRvalid, iErr, dErr, memWrite, memRead}, 32'd0);
        check({name, "_irdata"}, iRdata, 0);
        check({name, "_drdata"}, dRdata, 0);
        check({name, "_maddr"}, memAddress, 0);
        check({name, "_mdin"}, memDataIn, 0);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1;
        iReq = 0; dReq = 0; dWe = 0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        last_i = '0;
        last_d = '0;
    endtask

    task automatic do_txn(input logic isd, input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, output logic [DW-1:0] rd, output logic er);
        int  n;
        logic inr;
        inr = (addr < 512);
        @(negedge clk);
        if (isd) begin
            dReq = 1; dWe = we; dAddr = addr; dWdata = wdata;
        end else begin
            iReq = 1; iAddr = addr;
        end
        n = 0;
        do begin @(negedge clk); n++; end while (!(isd ? dGnt : iGnt) && n < 10);
        check("gnt_latency", n, 1);
        check("gnt_other", isd ? iGnt : dGnt, 0);
        check("mem_read", memRead, ~we & inr);
        check("mem_write", memWrite, we & inr);
        if (inr) check("mem_addr", memAddress, addr);
        iReq = 0; dReq = 0; dWe = 0;
        n = 0;
        do begin @(negedge clk); n++; end while (!(isd ? dRvalid : iRvalid) && n < 10);
        check("rvalid_latency", n, 2);
        rd = isd ? dRdata : iRdata;
        er = isd ? dErr : iErr;
    endtask

    typedef struct {
        logic          isd;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp_rd;
        logic          exp_er;
    } vec_t;

    vec_t vecs [12];
    logic [DW-1:0] exp_q [$];

    initial begin
        logic [DW-1:0] rd, mrd;
        logic          er, mer;
        int            n, ng, nr;
        int            gcyc [3];
        logic          owner [4];
        logic [AW-1:0] saddr [3];

        rst = 1'b1;
        iReq = 0; iAddr = '0; dReq = 0; dWe = 0; dAddr = '0; dWdata = '0;
        reset_dut();

        // ---- directed table ----
        vecs[0]  = '{1, 1, 0,   123, 0,   0};
        vecs[1]  = '{1, 0, 0,   0,   123, 0};
        vecs[2]  = '{1, 1, 1,   456, 123, 0};
        vecs[3]  = '{0, 0, 1,   0,   456, 0};
        vecs[4]  = '{1, 0, 600, 0,   0,   1};
        vecs[5]  = '{1, 1, 511, 9,   0,   0};
        vecs[6]  = '{1, 0, 511, 0,   9,   0};
        vecs[7]  = '{1, 1, 512, 55,  9,   1};
        vecs[8]  = '{1, 0, 512, 0,   0,   1};
        vecs[9]  = '{0, 0, 512, 0,   0,   1};
        vecs[10] = '{0, 0, 0,   0,   123, 0};
        vecs[11] = '{1, 0, 1,   0,   456, 0};
        for (int k = 0; k < 12; k++) begin
            do_txn(vecs[k].isd, vecs[k].we, vecs[k].addr, vecs[k].wdata, rd, er);
            model_txn(vecs[k].isd, vecs[k].we, vecs[k].addr, vecs[k].wdata, mrd, mer);
            check($sformatf("vec%0d_rdata", k), rd, vecs[k].exp_rd);
            check($sformatf("vec%0d_err", k), er, vecs[k].exp_er);
        end

        // ---- back-to-back write then read of the same address ----
        @(negedge clk);
        dReq = 1; dWe = 1; dAddr = 20; dWdata = 19'h5A5A5;
        n = 0;
        do begin @(negedge clk); n++; end while (!dGnt && n < 10);
        dWe = 0;
        n = 0;
        do begin @(negedge clk); n++; end while (!dGnt && n < 10);
        check("b2b_gnt_spacing", n, 2);
        check("b2b_write_rvalid", dRvalid, 1);
        dReq = 0;
        n = 0;
        do begin @(negedge clk); n++; end while (!dRvalid && n < 10);
        check("b2b_rvalid_latency", n, 2);
        check("b2b_raw_data", dRdata, 19'h5A5A5);
        model_txn(1, 1, 20, 19'h5A5A5, mrd, mer);
        model_txn(1, 0, 20, 0, mrd, mer);

        // ---- randomized transactions against the model ----
        for (int k = 0; k < 40; k++) begin
            logic          isd, we;
            logic [AW-1:0] addr;
            logic [DW-1:0] wd;
            isd  = 1'($urandom_range(0, 1));
            we   = isd ? 1'($urandom_range(0, 1)) : 1'b0;
            addr = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(505, 520)) : AW'($urandom_range(0, 15));
            wd   = DW'($urandom);
            model_txn(isd, we, addr, wd, mrd, mer);
            do_txn(isd, we, addr, wd, rd, er);
            check($sformatf("rand%0d_rdata", k), rd, mrd);
            check($sformatf("rand%0d_err", k), er, mer);
        end

        // ---- reset during the ACCESS cycle of a write ----
        @(negedge clk);
        dReq = 1; dWe = 1; dAddr = 5; dWdata = 77;
        @(negedge clk);
        check("abort_in_access", {dGnt, memWrite}, 2'b11);
        #2 rst = 1'b1;
        #1 check_all_zero("abort");
        dReq = 0; dWe = 0;
        last_i = '0;
        last_d = '0;
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (dRvalid | iRvalid) n++;
        end
        check("abort_no_rvalid", n, 0);
        model_txn(1, 0, 5, 0, mrd, mer);
        do_txn(1, 0, 5, 0, rd, er);
        check("abort_read5", rd, mrd);

        // ---- both ports requesting continuously ----
        reset_dut();
        @(negedge clk);
        iReq = 1; iAddr = 2; dReq = 1; dWe = 0; dAddr = 3;
        ng = 0;
        n = 0;
        while (ng < 4 && n < 30) begin
            @(negedge clk);
            n++;
            if (iGnt | dGnt) begin
                check("tie_one_gnt", {iGnt, dGnt} == 2'b11, 0);
                owner[ng] = dGnt;
                ng++;
            end
        end
        iReq = 0; dReq = 0;
        check("tie_gnt_count", ng, 4);
        for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_RR_EN
            check($sformatf("tie_owner%0d", k), owner[k], (k % 2 == 0) ? 1 : 0);
`else
            check($sformatf("tie_owner%0d", k), owner[k], 1);
`endif
        end
        repeat (4) @(negedge clk);

        // ---- instruction streaming 10, 11, 12 ----
        reset_dut();
        for (int k = 0; k < 3; k++) begin
            model_txn(1, 1, AW'(10 + k), DW'(1010 + k), mrd, mer);
            do_txn(1, 1, AW'(10 + k), DW'(1010 + k), rd, er);
        end
        for (int k = 0; k < 3; k++) begin
            saddr[k] = AW'(10 + k);
            model_txn(0, 0, saddr[k], 0, mrd, mer);
            exp_q.push_back(mrd);
        end
        @(negedge clk);
        iReq = 1; iAddr = saddr[0];
        ng = 0; nr = 0; n = 0;
        while (nr < 3 && n < 40) begin
            @(negedge clk);
            n++;
            if (iRvalid) begin
                if (exp_q.size() > 0) check($sformatf("stream_data%0d", nr), iRdata, exp_q.pop_front());
                nr++;
            end
            if (iGnt) begin
                if (ng < 3) gcyc[ng] = n;
                ng++;
                if (ng < 3) iAddr = saddr[ng]; else iReq = 0;
            end
        end
        iReq = 0;
        check("stream_rvalid_count", nr, 3);
        check("stream_gnt_count", ng, 3);
        if (ng >= 3) begin
            check("stream_gap01", gcyc[1] - gcyc[0], 2);
            check("stream_gap12", gcyc[2] - gcyc[1], 2);
        end

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
